pellet_tracker: RTL and testbench

Owns the pellet map for the Pac-Man maze: writes a per-tile pellet RAM from the maze ROM at start, clears the tile under the player once per frame, and keeps score. It sits between the player-motion block, which supplies BallX/BallY, and the colour mapper, which reads pellet presence per pixel. The player block only reads the maze; this block is the maze-state writer.

---
 rtl/pellet_tracker.sv | 180 ++++++++++++++++++
 tb/tb_pellet_tracker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_tracker.sv
// pellet_tracker: owner of the per-tile pellet map for the maze.
//   - INIT copies the external pellet-mask ROM into a 1200x1 dual-port RAM and counts pellets.
//   - Once per frame, the tile under the player is read, and if it holds a pellet the tile is
//     cleared, the score is bumped (saturating) and the pellet count drops.
//   - Port B of the RAM serves the renderer: pellet_on marks the dot in the middle of each tile.
// Ports:
//   vga_clk, Reset_n        clock, async active-low reset
//   restart, frame_tick     1-cycle control pulses
//   BallX, BallY            player centre (pixels)
//   init_addr, init_pellet  mask ROM address out, registered ROM data in
//   DrawX, DrawY, pellet_on renderer pixel in, dot flag out (1-cycle latency)
//   score, pellets_left, eat_pulse, level_clear, busy   status outputs
module pellet_tracker #(
  parameter int unsigned TILE_LOG2  = 4,
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned PELLET_PTS = 10
) (
  input  logic        vga_clk,
  input  logic        Reset_n,
  input  logic        restart,
  input  logic        frame_tick,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  output logic [10:0] init_addr,
  input  logic        init_pellet,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        pellet_on,
  output logic [15:0] score,
  output logic [10:0] pellets_left,
  output logic        eat_pulse,
  output logic        level_clear,
  output logic        busy
);

  localparam int unsigned Tiles  = COLS * ROWS;
  localparam logic [9:0]  XLimit = 10'(COLS << TILE_LOG2);
  localparam logic [9:0]  YLimit = 10'(ROWS << TILE_LOG2);
  localparam logic [10:0] LastCnt = 11'(Tiles);

  typedef enum logic [2:0] {StInit, StIdle, StRead, StCheck, StWrite} state_e;

  // Only meaningful for in-range coordinates; callers gate with the range check.
  function automatic logic [10:0] tile_of(input logic [9:0] x, input logic [9:0] y);
    return 11'(11'(y >> TILE_LOG2) * 11'(COLS)) + 11'(x >> TILE_LOG2);
  endfunction

  state_e      state_q;
  logic [10:0] cnt_q;
  logic [10:0] tile_q;
  logic [15:0] score_q;
  logic [10:0] left_q;
  logic        eat_q;
  logic        clear_q;
  logic        busy_q;
  logic        pix_ok_q;

  logic        mem [Tiles];
  logic        a_rd_q;
  logic        b_rd_q;

  logic        we_a;
  logic        wd_a;
  logic [10:0] addr_a;
  logic [10:0] addr_b;
  logic        ball_ok;
  logic [10:0] ball_tile;
  logic        draw_ok;
  logic        draw_dot;
  logic [16:0] score_sum;

  assign ball_ok   = (BallX < XLimit) && (BallY < YLimit);
  assign ball_tile = tile_of(BallX, BallY);
  assign draw_ok   = (DrawX < XLimit) && (DrawY < YLimit);
  // Out-of-range pixels still read a legal RAM word; the range term masks the result.
  assign addr_b    = draw_ok ? tile_of(DrawX, DrawY) : '0;
  assign draw_dot  = draw_ok && (DrawX[3:0] >= 4'd6) && (DrawX[3:0] <= 4'd9) &&
                     (DrawY[3:0] >= 4'd6) && (DrawY[3:0] <= 4'd9);
  assign score_sum = {1'b0, score_q} + 17'(PELLET_PTS);

  // Port A: INIT writes the ROM byte for the previous address; WRITE clears the latched tile.
  always_comb begin
    we_a   = 1'b0;
    wd_a   = 1'b0;
    addr_a = tile_q;
    if (!restart) begin
      case (state_q)
        StInit: begin
          if (cnt_q != '0) begin
            we_a   = 1'b1;
            wd_a   = init_pellet;
            addr_a = cnt_q - 11'd1;
          end
        end
        StWrite: we_a = 1'b1;
        default: ;
      endcase
    end
  end

  // Dual-port RAM; port B sees old data when port A writes the same word.
  always_ff @(posedge vga_clk) begin
    if (we_a) mem[addr_a] <= wd_a;
    a_rd_q <= mem[addr_a];
    b_rd_q <= mem[addr_b];
  end

  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StInit;
      cnt_q    <= '0;
      tile_q   <= '0;
      score_q  <= '0;
      left_q   <= '0;
      eat_q    <= 1'b0;
      clear_q  <= 1'b0;
      busy_q   <= 1'b1;
      pix_ok_q <= 1'b0;
    end else begin
      pix_ok_q <= draw_dot;
      eat_q    <= 1'b0;
      if (restart) begin
        state_q <= StInit;
        cnt_q   <= '0;
        score_q <= '0;
        left_q  <= '0;
        clear_q <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          StInit: begin
            if ((cnt_q != '0) && init_pellet) left_q <= left_q + 11'd1;
            if (cnt_q == LastCnt) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              if ((left_q + 11'(init_pellet)) == '0) clear_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 11'd1;
            end
          end
          StIdle: begin
            if (frame_tick && ball_ok) begin
              tile_q  <= ball_tile;
              state_q <= StRead;
            end
          end
          StRead: state_q <= StCheck;
          StCheck: begin
            if (a_rd_q) begin
              // Counters update on entry to WRITE so they are visible with eat_pulse.
              state_q <= StWrite;
              eat_q   <= 1'b1;
              score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
              left_q  <= left_q - 11'd1;
            end else begin
              state_q <= StIdle;
              if (left_q == '0) clear_q <= 1'b1;
            end
          end
          StWrite: begin
            state_q <= StIdle;
            if (left_q == '0) clear_q <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // The counter runs one past the last tile to flush the final ROM word; hold the address.
  assign init_addr    = (cnt_q == LastCnt) ? LastCnt - 11'd1 : cnt_q;
  assign pellet_on    = b_rd_q & pix_ok_q;
  assign score        = score_q;
  assign pellets_left = left_q;
  assign eat_pulse    = eat_q;
  assign level_clear  = clear_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pellet_tracker.sv
// Self-checking bench for pellet_tracker: a tile-map model tracks pellets, score and level state.
module tb_pellet_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  ball_x = '0;
  logic [9:0]  ball_y = '0;
  logic [9:0]  draw_x = '0;
  logic [9:0]  draw_y = '0;
  logic        init_pellet = 1'b0;
  logic [10:0] init_addr;
  logic        pellet_on;
  logic [15:0] score;
  logic [10:0] pellets_left;
  logic        eat_pulse;
  logic        level_clear;
  logic        busy;

  bit rom  [1200];
  bit pmap [1200];
  int m_score;
  int m_left;
  bit m_clear;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Synchronous mask ROM: data follows the address by one cycle.
  always @(posedge clk) init_pellet <= (init_addr < 11'd1200) ? rom[init_addr] : 1'b0;

  pellet_tracker dut (
    .vga_clk     (clk),
    .Reset_n     (rst_n),
    .restart     (restart),
    .frame_tick  (frame_tick),
    .BallX       (ball_x),
    .BallY       (ball_y),
    .init_addr   (init_addr),
    .init_pellet (init_pellet),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .pellet_on   (pellet_on),
    .score       (score),
    .pellets_left(pellets_left),
    .eat_pulse   (eat_pulse),
    .level_clear (level_clear),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input int x, input int y);
    return (x < 640) && (y < 480);
  endfunction

  function automatic int tile(input int x, input int y);
    return (y / 16) * 40 + (x / 16);
  endfunction

  function automatic bit dot_exp(input int x, input int y);
    if (!in_rng(x, y)) return 1'b0;
    return pmap[tile(x, y)] && (x % 16 >= 6) && (x % 16 <= 9) && (y % 16 >= 6) && (y % 16 <= 9);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_model();
    m_left = 0;
    for (int i = 0; i < 1200; i++) begin
      pmap[i] = rom[i];
      m_left += int'(rom[i]);
    end
    m_score = 0;
    m_clear = (m_left == 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin
      step();
      k++;
    end
    check_eq("idle_timeout", busy, 0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic eat_model(input int x, input int y, output bit hit);
    hit = in_rng(x, y) && pmap[tile(x, y)];
    if (hit) begin
      pmap[tile(x, y)] = 1'b0;
      m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
      m_left--;
    end
  endtask

  // One frame tick at (x,y); checks the pulse window t+1..t+4.
  task automatic tick_at(input int x, input int y);
    bit hit;
    ball_x = 10'(x);
    ball_y = 10'(y);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check_eq("eat_early1", eat_pulse, 0);
    step();
    check_eq("eat_early2", eat_pulse, 0);
    step();
    eat_model(x, y, hit);
    check_eq("eat_pulse", eat_pulse, hit);
    check_eq("score", score, m_score);
    check_eq("pellets_left", pellets_left, m_left);
    step();
    if (m_left == 0) m_clear = 1'b1;
    check_eq("eat_len", eat_pulse, 0);
    check_eq("level_clear", level_clear, m_clear);
  endtask

  task automatic draw_check(input int x, input int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    step();
    check_eq("pellet_on", pellet_on, dot_exp(x, y));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int x;
    int y;
    int mode;
    int pick;
    bit hit;

    for (int i = 0; i < 1200; i++) rom[i] = 1'b1;

    // Reset values
    repeat (3) step();
    check_eq("rst_busy", busy, 1);
    check_eq("rst_init_addr", init_addr, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_left", pellets_left, 0);
    check_eq("rst_clear", level_clear, 0);
    check_eq("rst_eat", eat_pulse, 0);
    check_eq("rst_pellet_on", pellet_on, 0);

    // INIT length with an all-ones mask
    rst_n = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (busy && k < 2000);
    check_eq("init_cycles", k, 1201);
    load_model();
    check_eq("init_left", pellets_left, 1200);
    check_eq("init_score", score, 0);
    check_eq("init_clear", level_clear, 0);

    // Directed eat and repeat at the same spot
    tick_at(100, 50);
    tick_at(100, 50);
    // Out of range
    tick_at(650, 50);
    tick_at(20, 500);

    // A tick while busy is dropped, not queued
    ball_x = 10'd200;
    ball_y = 10'd200;
    frame_tick = 1'b1;
    step();
    ball_x = 10'd300;
    ball_y = 10'd300;
    step();
    frame_tick = 1'b0;
    step();
    eat_model(200, 200, hit);
    check_eq("busy_tick_eat", eat_pulse, 1);
    check_eq("busy_tick_score", score, m_score);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      k += int'(eat_pulse);
    end
    check_eq("busy_tick_dropped", k, 0);
    check_eq("busy_tick_left", pellets_left, m_left);

    // Renderer
    draw_check(103, 55);
    draw_check(119, 55);
    draw_check(96, 48);
    draw_check(700, 55);

    // Randomised frames
    x = 0;
    y = 0;
    for (int i = 0; i < 120; i++) begin
      mode = int'($urandom_range(0, 3));
      if (mode < 2) begin
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
      end else if (mode == 3) begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end
      tick_at(x, y);
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        x = int'($urandom_range(0, 39)) * 16 + int'($urandom_range(5, 10));
        y = int'($urandom_range(0, 29)) * 16 + int'($urandom_range(5, 10));
      end else begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end
      draw_check(x, y);
    end

    // Restart mid-INIT with a sparse random mask
    for (int i = 0; i < 1200; i++) rom[i] = ($urandom_range(0, 9) < 3);
    rom[10] = 1'b1;
    do_restart();
    check_eq("restart_busy", busy, 1);
    check_eq("restart_score", score, 0);
    k = 0;
    while (init_addr != 11'd600 && k < 2000) begin
      step();
      k++;
    end
    check_eq("reach_600", init_addr, 600);
    do_restart();
    check_eq("reinit_addr", init_addr, 0);
    check_eq("reinit_busy", busy, 1);
    check_eq("reinit_left", pellets_left, 0);
    wait_idle();
    load_model();
    check_eq("pop_left", pellets_left, m_left);
    check_eq("pop_score", score, 0);
    check_eq("pop_clear", level_clear, m_clear);

    // Restart in WRITE
    ball_x = 10'(10 * 16 + 8);
    ball_y = 10'd8;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    check_eq("write_eat", eat_pulse, 1);
    check_eq("write_score", score, 10);
    do_restart();
    check_eq("abort_score", score, 0);
    check_eq("abort_left", pellets_left, 0);
    check_eq("abort_busy", busy, 1);
    check_eq("abort_eat", eat_pulse, 0);
    wait_idle();
    load_model();
    check_eq("abort_pop", pellets_left, m_left);
    check_eq("abort_clear", level_clear, 0);
    draw_check(10 * 16 + 7, 7);

    // Single pellet at tile 5
    for (int i = 0; i < 1200; i++) rom[i] = 1'b0;
    rom[5] = 1'b1;
    do_restart();
    wait_idle();
    load_model();
    check_eq("single_left", pellets_left, 1);
    check_eq("single_clear", level_clear, 0);
    tick_at(88, 8);
    check_eq("single_cleared", level_clear, 1);
    tick_at(300, 100);
    check_eq("clear_held", level_clear, 1);

    // Asynchronous reset mid-run
    pick = m_score;
    check_eq("pre_async_score", score, pick);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_score", score, 0);
    check_eq("async_busy", busy, 1);
    check_eq("async_clear", level_clear, 0);
    check_eq("async_addr", init_addr, 0);
    step();
    rst_n = 1'b1;
    wait_idle();
    load_model();
    check_eq("async_left", pellets_left, 1);

    // Empty mask clears the level straight out of INIT
    rom[5] = 1'b0;
    do_restart();
    wait_idle();
    load_model();
    check_eq("empty_left", pellets_left, 0);
    check_eq("empty_clear", level_clear, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
